// File: rtl/shear_sort_ctrl.sv
// shear_sort_ctrl: global phase/step sequencer for the shear-sort mesh.
// It walks row, column and final-row odd-even transposition phases and
// broadcasts one compare-exchange step per unstalled cycle to every PE.
module shear_sort_ctrl #(
  parameter int SIDE     = 16,
  parameter int LOG_SIDE = 4,
  parameter int PHASE_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  output logic                sort_en,
  output logic                row_mode,
  output logic                parity,
  output logic [PHASE_W-1:0]  phase,
  output logic [LOG_SIDE-1:0] step,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LOG_SIDE-1:0] LAST_STEP  = LOG_SIDE'(SIDE - 1);
  localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(2 * LOG_SIDE);

  state_t                state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [LOG_SIDE-1:0]   step_q, step_d;
  logic                  active;

  // Sequencer registers; reset drops straight back to IDLE with zeroed counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic: step through each phase, toggle ROW/COL at phase ends,
  // and leave through DONE after the last step of the final row phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROW;
          phase_d = '0;
          step_d  = '0;
        end
      end
      ROW, COL: begin
        if (!stall) begin
          if (step_q == LAST_STEP) begin
            step_d = '0;
            if (phase_q == LAST_PHASE) begin
              state_d = DONE;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
              state_d = (state_q == ROW) ? COL : ROW;
            end
          end else begin
            step_d = step_q + LOG_SIDE'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
        step_d  = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        step_d  = '0;
      end
    endcase
  end

  // Output decode from registered state; stall only gates the compare enable.
  always_comb begin
    active   = (state_q == ROW) || (state_q == COL);
    busy     = active;
    sort_en  = active && !stall;
    row_mode = (state_q == ROW);
    parity   = active && step_q[0];
    phase    = phase_q;
    step     = step_q;
    done     = (state_q == DONE);
  end

endmodule

// File: tb/tb_shear_sort_ctrl.sv
// tb_shear_sort_ctrl: checks a default-size and a SIDE=4 sequencer against
// a schedule model that counts issued steps and derives phase/step from it.
module tb_shear_sort_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic startIn [2];
  logic stallIn [2];

  logic       en16, row16, par16, busy16, done16;
  logic [7:0] phase16;
  logic [3:0] step16;
  logic       en4, row4, par4, busy4, done4;
  logic [7:0] phase4;
  logic [1:0] step4;

  int checks = 0;
  int errors = 0;

  int mIdx    [2];
  bit mActive [2];
  bit mDone   [2];

  // Free-running clock
  always #5 clk = ~clk;

  shear_sort_ctrl #(.SIDE(16), .LOG_SIDE(4), .PHASE_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .start(startIn[0]), .stall(stallIn[0]),
    .sort_en(en16), .row_mode(row16), .parity(par16), .phase(phase16),
    .step(step16), .busy(busy16), .done(done16)
  );

  shear_sort_ctrl #(.SIDE(4), .LOG_SIDE(2), .PHASE_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(startIn[1]), .stall(stallIn[1]),
    .sort_en(en4), .row_mode(row4), .parity(par4), .phase(phase4),
    .step(step4), .busy(busy4), .done(done4)
  );

  function automatic int sideOf(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int totalOf(input int i);
    int lg = (i == 0) ? 4 : 2;
    return sideOf(i) * (2 * lg + 1);
  endfunction

  // Output bundle: {sort_en, row_mode, parity, busy, done, phase[7:0], step[3:0]}
  function automatic logic [16:0] dutVec(input int i);
    if (i == 0) return {en16, row16, par16, busy16, done16, phase16, step16};
    return {en4, row4, par4, busy4, done4, phase4, 2'b00, step4};
  endfunction

  function automatic logic [16:0] modelVec(input int i);
    int s  = sideOf(i);
    int ph = mIdx[i] / s;
    int st = mIdx[i] % s;
    logic [16:0] v = '0;
    if (mActive[i]) begin
      v[16]   = !stallIn[i];
      v[15]   = (ph % 2 == 0);
      v[14]   = (st % 2 == 1);
      v[13]   = 1'b1;
      v[11:4] = 8'(ph);
      v[3:0]  = 4'(st);
    end
    v[12] = mDone[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [16:0] actual,
                             input logic [16:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Schedule model: an issued-step counter per instance, advanced on unstalled edges
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mActive[i] <= 1'b0;
        mDone[i]   <= 1'b0;
        mIdx[i]    <= 0;
      end else if (mDone[i]) begin
        mDone[i] <= 1'b0;
      end else if (mActive[i]) begin
        if (!stallIn[i]) begin
          if (mIdx[i] + 1 == totalOf(i)) begin
            mActive[i] <= 1'b0;
            mDone[i]   <= 1'b1;
            mIdx[i]    <= 0;
          end else begin
            mIdx[i] <= mIdx[i] + 1;
          end
        end
      end else if (startIn[i]) begin
        mActive[i] <= 1'b1;
        mIdx[i]    <= 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model, mid-cycle
  always @(negedge clk) begin
    checkOutput("cycle_side16", dutVec(0), modelVec(0));
    checkOutput("cycle_side4", dutVec(1), modelVec(1));
  end

  // One sort run: start pulse (or held start), optional stalls at cycle offsets k
  // after the accepting edge; gathers run statistics up to the done cycle.
  task automatic applyStimulus(input int inst, input bit holdStart,
                               input int stallK0, input int stallLen0, input int stallK1,
                               output int doneAt, output int enCnt, output int rowCnt,
                               output int parCnt, output int maxPhase);
    logic [16:0] v;
    doneAt = 0; enCnt = 0; rowCnt = 0; parCnt = 0; maxPhase = 0;
    @(posedge clk); #1;
    startIn[inst] = 1'b1;
    @(posedge clk); #1;
    if (!holdStart) startIn[inst] = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      stallIn[inst] = ((k >= stallK0) && (k < stallK0 + stallLen0)) || (k == stallK1);
      @(negedge clk);
      v = dutVec(inst);
      if (v[16]) begin
        enCnt++;
        if (v[15]) rowCnt++;
        if (v[14]) parCnt++;
      end
      if (int'(v[11:4]) > maxPhase) maxPhase = int'(v[11:4]);
      if (v[12]) begin
        doneAt = k;
        break;
      end
      @(posedge clk); #1;
    end
    stallIn[inst] = 1'b0;
    if (doneAt == 0) checkOutput("done_timeout", 17'd0, 17'd1);
  endtask

  initial begin
    int doneAt, enCnt, rowCnt, parCnt, maxPhase;
    bit seen;
    startIn[0] = 1'b0; startIn[1] = 1'b0;
    stallIn[0] = 1'b0; stallIn[1] = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_side16", dutVec(0), 17'd0);
    checkOutput("reset_side4", dutVec(1), 17'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] idle for 50 cycles");
    repeat (50) @(posedge clk);
    #1;
    checkOutput("idle_side16", dutVec(0), 17'd0);

    $display("[TB] plain run, SIDE=16");
    applyStimulus(0, 1'b0, 0, 0, 0, doneAt, enCnt, rowCnt, parCnt, maxPhase);
    checkOutput("run_en_count", 17'(enCnt), 17'd144);
    checkOutput("run_done_at", 17'(doneAt), 17'd145);
    checkOutput("run_row_cycles", 17'(rowCnt), 17'd80);
    checkOutput("run_odd_parity", 17'(parCnt), 17'd72);
    checkOutput("run_max_phase", 17'(maxPhase), 17'd8);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 17'(done16), 17'd0);

    $display("[TB] stalled run, SIDE=16");
    applyStimulus(0, 1'b0, 48, 3, 132, doneAt, enCnt, rowCnt, parCnt, maxPhase);
    checkOutput("stall_en_count", 17'(enCnt), 17'd144);
    checkOutput("stall_done_at", 17'(doneAt), 17'd149);
    @(posedge clk); #1;

    $display("[TB] held start, SIDE=16");
    applyStimulus(0, 1'b1, 0, 0, 0, doneAt, enCnt, rowCnt, parCnt, maxPhase);
    checkOutput("hold_done_at", 17'(doneAt), 17'd145);
    @(posedge clk); #1;
    checkOutput("hold_idle_gap", dutVec(0), 17'd0);
    @(posedge clk); #1;
    checkOutput("hold_restart", dutVec(0), {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0});
    startIn[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done16) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("hold_second_done", 17'(seen), 17'd1);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] async reset mid-sort");
    startIn[0] = 1'b1;
    @(posedge clk); #1;
    startIn[0] = 1'b0;
    repeat (87) @(posedge clk);
    #1;
    checkOutput("pre_reset_pos", {9'd0, phase16, step16} , {9'd0, 8'd5, 4'd7});
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_side16", dutVec(0), 17'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", dutVec(0), 17'd0);

    $display("[TB] plain run, SIDE=4");
    applyStimulus(1, 1'b0, 0, 0, 0, doneAt, enCnt, rowCnt, parCnt, maxPhase);
    checkOutput("s4_en_count", 17'(enCnt), 17'd20);
    checkOutput("s4_done_at", 17'(doneAt), 17'd21);
    checkOutput("s4_row_cycles", 17'(rowCnt), 17'd12);
    checkOutput("s4_odd_parity", 17'(parCnt), 17'd10);
    checkOutput("s4_max_phase", 17'(maxPhase), 17'd4);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
